// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Sequences the 16-bit ALU datapath between instruction decode and register
//   writeback. It accepts one request at a time and returns a registered
//   result with S/Z/C/V flags. ADD/SUB/AND/OR finish in one cycle. Shifts
//   (SLA/SRA/SLL/SRL) move one bit per clock.
//
// Ports
//   clk, rst_n            : clock (rising edge) and async active-low reset
//   req_valid/req_ready   : request handshake; req_op, req_a, req_b are
//                           sampled only at the accept edge
//   res_valid/res_ready   : result handshake; res_data and res_s/z/c/v are
//                           held stable while res_valid is high
//   busy                  : high whenever the sequencer is not idle
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_s,
  output logic             res_z,
  output logic             res_c,
  output logic             res_v,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Shift kind is req_op[1:0] of the shift ops: 4 SLA, 5 SRA, 6 SLL, 7 SRL.
  localparam logic [1:0]     KIND_SLA = 2'd0;
  localparam logic [1:0]     KIND_SRA = 2'd1;
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
  logic             sv_q, sv_d;          // sticky SLA overflow
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_s_q, res_s_d, res_z_q, res_z_d;
  logic             res_c_q, res_c_d, res_v_q, res_v_d;
  logic             res_valid_q, res_valid_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;

  logic             load_s;
  logic [WIDTH-1:0] ld_data_s;
  logic             ld_c_s, ld_v_s;
  logic [WIDTH:0]   sum_s, diff_s;
  logic [WIDTH-1:0] step_s;
  logic             out_bit_s, msb_chg_s, fill_s;

  // One-bit shift step of the work register and its side effects.
  always_comb begin
    step_s    = work_q;
    out_bit_s = 1'b0;
    fill_s    = (kind_q == KIND_SRA) ? work_q[WIDTH-1] : 1'b0;
    msb_chg_s = (kind_q == KIND_SLA) && (work_q[WIDTH-1] != work_q[WIDTH-2]);
    if (kind_q[0] == 1'b0) begin
      step_s    = {work_q[WIDTH-2:0], 1'b0};
      out_bit_s = work_q[WIDTH-1];
    end else begin
      step_s    = {fill_s, work_q[WIDTH-1:1]};
      out_bit_s = work_q[0];
    end
  end

  // Next-state logic and selection of the value captured on entry to DONE.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    sv_d      = sv_q;
    load_s    = 1'b0;
    ld_data_s = {WIDTH{1'b0}};
    ld_c_s    = 1'b0;
    ld_v_s    = 1'b0;
    // Bit WIDTH of the zero-extended sum/difference is carry/borrow.
    sum_s     = {1'b0, req_a} + {1'b0, req_b};
    diff_s    = {1'b0, req_a} - {1'b0, req_b};
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op)
            3'd0: begin
              load_s    = 1'b1;
              ld_data_s = sum_s[WIDTH-1:0];
              ld_c_s    = sum_s[WIDTH];
              ld_v_s    = (req_a[WIDTH-1] == req_b[WIDTH-1]) &&
                          (sum_s[WIDTH-1] != req_a[WIDTH-1]);
              state_d   = ST_DONE;
            end
            3'd1: begin
              load_s    = 1'b1;
              ld_data_s = diff_s[WIDTH-1:0];
              ld_c_s    = diff_s[WIDTH];
              ld_v_s    = (req_a[WIDTH-1] != req_b[WIDTH-1]) &&
                          (diff_s[WIDTH-1] != req_a[WIDTH-1]);
              state_d   = ST_DONE;
            end
            3'd2: begin
              load_s    = 1'b1;
              ld_data_s = req_a & req_b;
              state_d   = ST_DONE;
            end
            3'd3: begin
              load_s    = 1'b1;
              ld_data_s = req_a | req_b;
              state_d   = ST_DONE;
            end
            default: begin
              // Remaining opcodes are the shift family.
              if (req_b[SHW-1:0] == {SHW{1'b0}}) begin
                load_s    = 1'b1;
                ld_data_s = req_a;
                state_d   = ST_DONE;
              end else begin
                work_d  = req_a;
                cnt_d   = req_b[SHW-1:0];
                kind_d  = req_op[1:0];
                sv_d    = 1'b0;
                state_d = ST_SHIFT;
              end
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = step_s;
        cnt_d  = cnt_q - CNT_ONE;
        sv_d   = sv_q | msb_chg_s;
        if (cnt_q == CNT_ONE) begin
          load_s    = 1'b1;
          ld_data_s = step_s;
          ld_c_s    = out_bit_s;
          ld_v_s    = sv_q | msb_chg_s;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result/flag capture and handshake outputs, all computed for the next cycle.
  always_comb begin
    res_data_d  = res_data_q;
    res_c_d     = res_c_q;
    res_v_d     = res_v_q;
    res_s_d     = res_s_q;
    res_z_d     = res_z_q;
    if (load_s) begin
      res_data_d = ld_data_s;
      res_c_d    = ld_c_s;
      res_v_d    = ld_v_s;
      res_s_d    = ld_data_s[WIDTH-1];
      res_z_d    = (ld_data_s == {WIDTH{1'b0}});
    end else begin
      res_data_d = res_data_q;
    end
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= {WIDTH{1'b0}};
      cnt_q       <= {SHW{1'b0}};
      kind_q      <= 2'd0;
      sv_q        <= 1'b0;
      res_data_q  <= {WIDTH{1'b0}};
      res_s_q     <= 1'b0;
      res_z_q     <= 1'b0;
      res_c_q     <= 1'b0;
      res_v_q     <= 1'b0;
      res_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      kind_q      <= kind_d;
      sv_q        <= sv_d;
      res_data_q  <= res_data_d;
      res_s_q     <= res_s_d;
      res_z_q     <= res_z_d;
      res_c_q     <= res_c_d;
      res_v_q     <= res_v_d;
      res_valid_q <= res_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_s     = res_s_q;
  assign res_z     = res_z_q;
  assign res_c     = res_c_q;
  assign res_v     = res_v_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus randomized
// back-to-back traffic compared against a behavioural reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_s, res_z, res_c, res_v, busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_s(res_s), .res_z(res_z), .res_c(res_c), .res_v(res_v),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: whole-operation arithmetic, not a step-by-step shifter.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c, output logic v,
                                output int lat);
    int n;
    logic [16:0] w;
    logic [15:0] m;
    n = int'(b[3:0]);
    r = 16'h0; c = 1'b0; v = 1'b0; lat = 1;
    case (op)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'd1: begin
        w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      default: begin
        lat = 1 + n;
        if (n == 0) begin
          r = a;
        end else if (op == 3'd4 || op == 3'd6) begin
          r = a << n;
          c = a[16-n];
          if (op == 3'd4) begin
            // MSB changes at some step iff the top n+1 bits are not uniform.
            m = 16'hFFFF << (15 - n);
            v = ((a & m) != 16'h0) && ((a & m) != m);
          end
        end else if (op == 3'd5) begin
          r = $signed(a) >>> n;
          c = a[n-1];
        end else begin
          r = a >> n;
          c = a[n-1];
        end
      end
    endcase
  endfunction

  // Issue one request, wait for its result, optionally stall, then hand it off.
  // Observed values are returned; the calling scenario does the comparisons.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int hold,
                       output logic [15:0] d, output logic s, output logic z,
                       output logic c, output logic v,
                       output int lat, output int busy_cycles, output bit held_ok);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    lat = 1; busy_cycles = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    d = res_data; s = res_s; z = res_z; c = res_c; v = res_v;
    held_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_data !== d || res_s !== s || res_z !== z ||
          res_c !== c || res_v !== v || req_ready !== 1'b0) held_ok = 1'b0;
    end
    res_ready = 1'b1;
    if (busy === 1'b1) busy_cycles++;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_op = 3'd0; req_a = 16'h0; req_b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (res_data !== 16'h0) begin n_fail++; $display("FAIL reset_res_data got %h want 0000", res_data); end
    n_checks++; if ({res_s, res_z, res_c, res_v} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {res_s, res_z, res_c, res_v}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_directed();
    logic [15:0] d; logic s, z, c, v; int lat, bc; bit ok;
    do_op(3'd0, 16'h7FFF, 16'h0001, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if ({d, s, z, c, v} !== {16'h8000, 4'b1001} || lat != 1) begin n_fail++; $display("FAIL add_ovf got d=%h szcv=%b lat=%0d want d=8000 szcv=1001 lat=1", d, {s, z, c, v}, lat); end
    do_op(3'd1, 16'h0003, 16'h0005, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if ({d, s, z, c, v} !== {16'hFFFE, 4'b1010} || lat != 1) begin n_fail++; $display("FAIL sub_borrow got d=%h szcv=%b lat=%0d want d=fffe szcv=1010 lat=1", d, {s, z, c, v}, lat); end
    do_op(3'd1, 16'h1234, 16'h1234, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if ({d, s, z, c, v} !== {16'h0000, 4'b0100}) begin n_fail++; $display("FAIL sub_zero got d=%h szcv=%b want d=0000 szcv=0100", d, {s, z, c, v}); end
    do_op(3'd2, 16'hF0F0, 16'h3C3C, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if ({d, s, z, c, v} !== {16'h3030, 4'b0000}) begin n_fail++; $display("FAIL and got d=%h szcv=%b want d=3030 szcv=0000", d, {s, z, c, v}); end
    do_op(3'd3, 16'h8001, 16'h0100, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if ({d, s, z, c, v} !== {16'h8101, 4'b1000}) begin n_fail++; $display("FAIL or got d=%h szcv=%b want d=8101 szcv=1000", d, {s, z, c, v}); end
  endtask

  task automatic test_shift_directed();
    logic [15:0] d; logic s, z, c, v; int lat, bc; bit ok;
    do_op(3'd4, 16'h4001, 16'h0002, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if ({d, c, v} !== {16'h0004, 2'b11} || lat != 3) begin n_fail++; $display("FAIL sla2 got d=%h cv=%b lat=%0d want d=0004 cv=11 lat=3", d, {c, v}, lat); end
    n_checks++; if (bc != 3) begin n_fail++; $display("FAIL sla2_busy got %0d cycles want 3", bc); end
    do_op(3'd5, 16'h8000, 16'h000F, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if ({d, s, c} !== {16'hFFFF, 2'b10} || lat != 16) begin n_fail++; $display("FAIL sra15 got d=%h sc=%b lat=%0d want d=ffff sc=10 lat=16", d, {s, c}, lat); end
    do_op(3'd7, 16'h8001, 16'hFFF0, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if ({d, c, v} !== {16'h8001, 2'b00} || lat != 1) begin n_fail++; $display("FAIL srl0 got d=%h cv=%b lat=%0d want d=8001 cv=00 lat=1", d, {c, v}, lat); end
    do_op(3'd6, 16'h00F1, 16'h0004, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if ({d, c, v} !== {16'h0F10, 2'b00} || lat != 5) begin n_fail++; $display("FAIL sll4 got d=%h cv=%b lat=%0d want d=0f10 cv=00 lat=5", d, {c, v}, lat); end
  endtask

  task automatic test_backpressure();
    logic [15:0] d, a, b, er; logic s, z, c, v, ec, ev; int lat, bc, el; bit ok;
    a = 16'($urandom); b = 16'($urandom);
    model(3'd0, a, b, er, ec, ev, el);
    do_op(3'd0, a, b, 5, d, s, z, c, v, lat, bc, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_stable got %b want 1", ok); end
    n_checks++; if (d !== er || c !== ec || v !== ev) begin n_fail++; $display("FAIL hold_data got %h c%b v%b want %h c%b v%b", d, c, v, er, ec, ev); end
    n_checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL release_idle got rdy=%b val=%b busy=%b want 1 0 0", req_ready, res_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d, a, b, er; logic [2:0] op; logic s, z, c, v, ec, ev; int lat, bc, el, results; bit ok;
    results = 0;
    for (int k = 0; k < 80; k++) begin
      op = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom);
      if (k % 4 == 0) a = 16'($urandom_range(0, 3)) << 14;
      model(op, a, b, er, ec, ev, el);
      do_op(op, a, b, int'($urandom_range(0, 2)), d, s, z, c, v, lat, bc, ok);
      if (lat < 40) results++;
      n_checks++;
      if (d !== er || s !== er[15] || z !== (er == 16'h0) || c !== ec || v !== ev || lat != el || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL rand op=%0d a=%h b=%h got d=%h szcv=%b lat=%0d want d=%h szcv=%b lat=%0d",
                 op, a, b, d, {s, z, c, v}, lat, er, {er[15], er == 16'h0, ec, ev}, el);
      end
      n_checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rand_handoff got val=%b rdy=%b want 0 1", res_valid, req_ready); end
    end
    n_checks++; if (results != 80) begin n_fail++; $display("FAIL rand_count got %0d want 80", results); end
  endtask

  task automatic test_reset_mid_shift();
    logic [15:0] d; logic s, z, c, v; int lat, bc; bit ok;
    req_op = 3'd6; req_a = 16'hABCD; req_b = 16'h000A; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_shift_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 16'h0) begin
      n_fail++; $display("FAIL async_clear got busy=%b rdy=%b val=%b d=%h want 0 1 0 0000", busy, req_ready, res_valid, res_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got val=%b busy=%b want 0 0", res_valid, busy); end
    do_op(3'd0, 16'h0002, 16'h0003, 0, d, s, z, c, v, lat, bc, ok);
    n_checks++; if (d !== 16'h0005 || {s, z, c, v} !== 4'b0000 || lat != 1) begin n_fail++; $display("FAIL post_reset_add got d=%h szcv=%b lat=%0d want d=0005 szcv=0000 lat=1", d, {s, z, c, v}, lat); end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_shift_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
